// File: rtl/wb_seq_ctrl_pkg.sv
// Shared types and constants for the weight/bias memory sequencer.
//   seq_state_t : sequencer state encoding (3 bits)
//   *_DEF       : default geometry of the MNIST layer-1/layer-2 banks
//   L*_ROWS     : rows per bank including the trailing bias row
//   L*_BIAS_IDX : address of the bias row in each bank
package wb_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_L1       = 3'd1,
        ST_L1_DRAIN = 3'd2,
        ST_WAIT_ACT = 3'd3,
        ST_L2       = 3'd4,
        ST_L2_DRAIN = 3'd5
    } seq_state_t;

    localparam int N_IN_DEF    = 784;
    localparam int N_HID_DEF   = 32;
    localparam int AW_DEF      = 32;
    localparam int FW_DEF      = 16;

    localparam int L1_ROWS     = N_IN_DEF + 1;
    localparam int L2_ROWS     = N_HID_DEF + 1;
    localparam int L1_BIAS_IDX = N_IN_DEF;
    localparam int L2_BIAS_IDX = N_HID_DEF;

endpackage

// File: rtl/wb_seq_ctrl_addr_cnt.sv
// Row-address counter for one weight bank.
//   clk, reset  : clock, async active-high reset
//   i_clr       : restart addressing at row 0
//   i_en        : a row is issued this cycle (read enable for this bank)
//   o_cnt       : current row address; saturates at LAST
//   o_at_last   : o_cnt is the bias row
//   o_valid     : registered copy of i_en (read data valid next cycle)
//   o_last      : registered "issued row was the bias row"
module wb_addr_cnt #(
    parameter int AW   = 32,
    parameter int LAST = 784
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [AW-1:0] o_cnt,
    output logic          o_at_last,
    output logic          o_valid,
    output logic          o_last
);

    localparam logic [AW-1:0] LAST_V = AW'(LAST);

    logic [AW-1:0] r_cnt;
    logic          r_valid;
    logic          r_last;

    assign o_at_last = (r_cnt == LAST_V);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_en && !o_at_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Strobes track the 1-cycle registered memory read.
            r_valid <= i_en;
            r_last  <= i_en && o_at_last;
        end
    end

    assign o_cnt   = r_cnt;
    assign o_valid = r_valid;
    assign o_last  = r_last;

endmodule

// File: rtl/wb_seq_ctrl.sv
// Weight/bias memory sequencer for the two-layer MNIST datapath.
// Walks the layer-1 bank (N_IN weights + bias), waits for the hidden
// activations, then walks the layer-2 bank (N_HID weights + bias).
//   clk, reset        : clock, async active-high reset
//   start             : begin one inference (IDLE only)
//   abort             : cancel, back to IDLE next cycle
//   stall             : MAC not ready, freeze address issue
//   act_ready         : hidden activations ready for layer 2
//   ctr1, ctr2        : layer-1 / layer-2 row addresses
//   re                : memory read enable
//   w1_valid/w2_valid : read data of layer 1 / layer 2 valid this cycle
//   w_last            : valid row is the bias row
//   l1_done, done     : pulses with the final layer-1 / layer-2 row
//   busy              : not IDLE
//   frames            : completed inference count
//
// state       | meaning
// ------------+------------------------------------------------
// ST_IDLE     | waiting for start
// ST_L1       | issuing layer-1 rows 0..N_IN
// ST_L1_DRAIN | final layer-1 row on the bus, l1_done
// ST_WAIT_ACT | waiting for act_ready
// ST_L2       | issuing layer-2 rows 0..N_HID
// ST_L2_DRAIN | final layer-2 row on the bus, done, frame counted
module wb_seq_ctrl
    import wb_seq_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_HID = N_HID_DEF,
    parameter int AW    = AW_DEF,
    parameter int FW    = FW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          stall,
    input  logic          act_ready,
    output logic [AW-1:0] ctr1,
    output logic [AW-1:0] ctr2,
    output logic          re,
    output logic          w1_valid,
    output logic          w2_valid,
    output logic          w_last,
    output logic          l1_done,
    output logic          done,
    output logic          busy,
    output logic [FW-1:0] frames
);

    seq_state_t    r_state;
    seq_state_t    w_next;
    logic [FW-1:0] r_frames;

    logic w_clr;
    logic w_issue1;
    logic w_issue2;
    logic w_at_last1;
    logic w_at_last2;
    logic w_last1;
    logic w_last2;

    // abort kills the read in its own cycle so no row leaks after cancel.
    assign re       = ((r_state == ST_L1) || (r_state == ST_L2)) && !stall && !abort;
    assign w_issue1 = re && (r_state == ST_L1);
    assign w_issue2 = re && (r_state == ST_L2);
    assign w_clr    = (r_state == ST_IDLE) && start;

    wb_addr_cnt #(.AW(AW), .LAST(N_IN)) u_cnt_l1 (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_clr),
        .i_en      (w_issue1),
        .o_cnt     (ctr1),
        .o_at_last (w_at_last1),
        .o_valid   (w1_valid),
        .o_last    (w_last1)
    );

    wb_addr_cnt #(.AW(AW), .LAST(N_HID)) u_cnt_l2 (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_clr),
        .i_en      (w_issue2),
        .o_cnt     (ctr2),
        .o_at_last (w_at_last2),
        .o_valid   (w2_valid),
        .o_last    (w_last2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_L1;
            end
            ST_L1: begin
                if (abort)                        w_next = ST_IDLE;
                else if (w_issue1 && w_at_last1)  w_next = ST_L1_DRAIN;
            end
            ST_L1_DRAIN: begin
                w_next = abort ? ST_IDLE : ST_WAIT_ACT;
            end
            ST_WAIT_ACT: begin
                if (abort)          w_next = ST_IDLE;
                else if (act_ready) w_next = ST_L2;
            end
            ST_L2: begin
                if (abort)                        w_next = ST_IDLE;
                else if (w_issue2 && w_at_last2)  w_next = ST_L2_DRAIN;
            end
            ST_L2_DRAIN: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frames <= '0;
        end else if (r_state == ST_L2_DRAIN) begin
            r_frames <= r_frames + 1'b1;
        end
    end

    // Bias-row strobes of each bank double as the layer completion pulses.
    assign w_last  = w_last1 || w_last2;
    assign l1_done = w_last1;
    assign done    = w_last2;
    assign busy    = (r_state != ST_IDLE);
    assign frames  = r_frames;

endmodule

// File: tb/tb_wb_seq_ctrl.sv
module tb_wb_seq_ctrl;

    localparam int N_IN  = 784;
    localparam int N_HID = 32;

    localparam int P_IDLE = 0;
    localparam int P_L1   = 1;
    localparam int P_L1D  = 2;
    localparam int P_WAIT = 3;
    localparam int P_L2   = 4;
    localparam int P_L2D  = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        stall;
    logic        act_ready;
    logic [31:0] ctr1;
    logic [31:0] ctr2;
    logic        re;
    logic        w1_valid;
    logic        w2_valid;
    logic        w_last;
    logic        l1_done;
    logic        done;
    logic        busy;
    logic [15:0] frames;

    wb_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .stall     (stall),
        .act_ready (act_ready),
        .ctr1      (ctr1),
        .ctr2      (ctr2),
        .re        (re),
        .w1_valid  (w1_valid),
        .w2_valid  (w2_valid),
        .w_last    (w_last),
        .l1_done   (l1_done),
        .done      (done),
        .busy      (busy),
        .frames    (frames)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: counts rows issued per layer, remembers what was
    // issued last cycle (the read pipeline), and tracks the frame phase.
    int m_phase, m_iss1, m_iss2, m_frames, m_pv_layer;
    bit m_pv_last;

    task automatic model_reset();
        m_phase = P_IDLE; m_iss1 = 0; m_iss2 = 0; m_frames = 0;
        m_pv_layer = 0; m_pv_last = 0;
    endtask

    function automatic bit model_re();
        return (m_phase == P_L1 || m_phase == P_L2) && !stall && !abort;
    endfunction

    function automatic logic [127:0] model_bundle();
        int c1, c2;
        c1 = (m_iss1 > N_IN)  ? N_IN  : m_iss1;
        c2 = (m_iss2 > N_HID) ? N_HID : m_iss2;
        return {41'd0, 32'(c1), 32'(c2), model_re(),
                m_pv_layer == 1, m_pv_layer == 2, m_pv_last,
                m_pv_layer == 1 && m_pv_last, m_pv_layer == 2 && m_pv_last,
                m_phase != P_IDLE, 16'(m_frames)};
    endfunction

    function automatic logic [127:0] dut_bundle();
        return {41'd0, ctr1, ctr2, re, w1_valid, w2_valid, w_last, l1_done, done, busy, frames};
    endfunction

    task automatic model_step();
        bit r;
        int old_phase;
        r = model_re();
        old_phase = m_phase;
        m_pv_layer = 0;
        m_pv_last  = 0;
        if (r && m_phase == P_L1) begin
            m_pv_layer = 1; m_pv_last = (m_iss1 == N_IN); m_iss1++;
        end else if (r && m_phase == P_L2) begin
            m_pv_layer = 2; m_pv_last = (m_iss2 == N_HID); m_iss2++;
        end
        if (abort && m_phase != P_IDLE) m_phase = P_IDLE;
        else begin
            case (m_phase)
                P_IDLE: if (start) begin m_phase = P_L1; m_iss1 = 0; m_iss2 = 0; end
                P_L1:   if (m_iss1 == N_IN + 1) m_phase = P_L1D;
                P_L1D:  m_phase = P_WAIT;
                P_WAIT: if (act_ready) m_phase = P_L2;
                P_L2:   if (m_iss2 == N_HID + 1) m_phase = P_L2D;
                default: m_phase = P_IDLE;
            endcase
        end
        if (old_phase == P_L2D) m_frames = (m_frames + 1) % 65536;
    endtask

    int ev_l1done, ev_done, ev_idle, n_w1, n_w2, n_last, n_l1done, n_done;

    task automatic clear_events();
        ev_l1done = -1; ev_done = -1; ev_idle = -1;
        n_w1 = 0; n_w2 = 0; n_last = 0; n_l1done = 0; n_done = 0;
    endtask

    // Inputs are already driven (posedge+1); sample at negedge, advance model.
    task automatic tick(input int c);
        @(negedge clk);
        check("cycle_outputs", dut_bundle(), model_bundle());
        if (l1_done)  begin ev_l1done = c; n_l1done++; end
        if (done)     begin ev_done = c;   n_done++;   end
        if (w1_valid) n_w1++;
        if (w2_valid) n_w2++;
        if (w_last)   n_last++;
        if (!busy && c > 0 && ev_idle < 0) ev_idle = c;
        model_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int stall_lo;
        int stall_hi;
        int act_rise;
        int start2;
        int exp_l1done;
        int exp_done;
        int exp_idle;
        int exp_w1;
        int exp_w2;
    } frame_vec_t;

    task automatic run_frame(input frame_vec_t v, input string tag);
        clear_events();
        for (int c = 0; c < 2000; c++) begin
            start     = (c == 0) || (c == v.start2);
            abort     = 1'b0;
            stall     = (c >= v.stall_lo) && (c <= v.stall_hi);
            act_ready = (c >= v.act_rise);
            tick(c);
            if (ev_idle >= 0) break;
        end
        start = 0; stall = 0; act_ready = 0;
        check({tag, "_l1done_cycle"}, 128'(ev_l1done), 128'(v.exp_l1done));
        check({tag, "_done_cycle"},   128'(ev_done),   128'(v.exp_done));
        check({tag, "_idle_cycle"},   128'(ev_idle),   128'(v.exp_idle));
        check({tag, "_w1_count"},     128'(n_w1),      128'(v.exp_w1));
        check({tag, "_w2_count"},     128'(n_w2),      128'(v.exp_w2));
        check({tag, "_last_count"},   128'(n_last),    128'(2));
        check({tag, "_done_count"},   128'(n_done),    128'(1));
    endtask

    frame_vec_t vecs[6];

    initial begin
        vecs[0] = '{-1,  -1,  0,   -1, 786, 821, 822, 785, 33};
        vecs[1] = '{10,  14,  0,   -1, 791, 826, 827, 785, 33};
        vecs[2] = '{-1,  -1,  807, -1, 786, 841, 842, 785, 33};
        vecs[3] = '{800, 802, 0,   -1, 786, 824, 825, 785, 33};
        vecs[4] = '{785, 785, 0,   -1, 787, 822, 823, 785, 33};
        vecs[5] = '{-1,  -1,  0,   300, 786, 821, 822, 785, 33};

        reset = 1; start = 0; abort = 0; stall = 0; act_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", dut_bundle(), 128'd0);
        reset = 0;
        model_reset();
        for (int i = 0; i < 3; i++) tick(0);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
            for (int k = 0; k < 3; k++) tick(0);
        end

        // abort with ctr1 = 400 (cycle 401)
        clear_events();
        for (int c = 0; c < 440; c++) begin
            start = (c == 0);
            abort = (c == 401);
            act_ready = 1;
            tick(c);
        end
        abort = 0; act_ready = 0;
        check("abort_idle_cycle", 128'(ev_idle),   128'(402));
        check("abort_w1_count",   128'(n_w1),      128'(400));
        check("abort_no_l1done",  128'(n_l1done),  128'(0));
        check("abort_no_done",    128'(n_done),    128'(0));
        check("abort_frames",     128'(frames),    128'(6));
        run_frame(vecs[0], "post_abort");

        // async reset mid-L2 with ctr2 = 17
        clear_events();
        for (int c = 0; c < 805; c++) begin
            start = (c == 0);
            act_ready = 1;
            tick(c);
        end
        start = 0;
        #2;
        check("ctr2_before_reset", 128'(ctr2), 128'(17));
        reset = 1;
        #1;
        check("async_reset_mid_l2", dut_bundle(), 128'd0);
        @(posedge clk);
        #1;
        reset = 0; act_ready = 0;
        model_reset();
        for (int i = 0; i < 3; i++) tick(0);

        // randomized traffic against the model
        clear_events();
        for (int c = 0; c < 9000; c++) begin
            start     = ($urandom_range(0, 39) == 0);
            stall     = ($urandom_range(0, 5) == 0);
            act_ready = ($urandom_range(0, 2) == 0);
            abort     = ($urandom_range(0, 2999) == 0);
            tick(c);
        end
        start = 0; stall = 0; act_ready = 0; abort = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_seq_ctrl.md
Name: wb_seq_ctrl

Overview:
- Sequencer for the MNIST weight/bias memory banks: layer-1 bank (32 lanes, 785 rows = 784 pixel weights + bias) and layer-2 bank (10 lanes, 33 rows = 32 hidden weights + bias).
- Drives ctr1, ctr2 and re, and produces valid/last strobes aligned to the 1-cycle registered read.
- Sits between the top-level inference FSM (start/done) and the MAC arrays (stall, act_ready).

Parameters:
- N_IN, 784, layer-1 input count; layer-1 bias row index = N_IN.
- N_HID, 32, hidden count; layer-2 bias row index = N_HID.
- AW, 32, ctr1/ctr2 width; matches the memory address ports.
- FW, 16, frame counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin one inference; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE next cycle
- stall  in  1  MAC not ready; freezes address issue
- act_ready  in  1  hidden activations latched and ready for layer 2
- ctr1  out  AW  layer-1 row address
- ctr2  out  AW  layer-2 row address
- re  out  1  memory read enable
- w1_valid  out  1  layer-1 weight outputs hold a newly read row this cycle
- w2_valid  out  1  layer-2 weight outputs hold a newly read row this cycle
- w_last  out  1  the valid row is the bias row (qualifies w1_valid/w2_valid)
- l1_done  out  1  one-cycle pulse with the last w1_valid
- done  out  1  one-cycle pulse with the last w2_valid
- busy  out  1  high in every state except IDLE
- frames  out  FW  completed-inference count, wraps at 2^FW

Behaviour:
- States: IDLE, L1, L1_DRAIN, WAIT_ACT, L2, L2_DRAIN.
- Reset (async) values: state IDLE; ctr1=0, ctr2=0, re=0, w1_valid=0, w2_valid=0, w_last=0, l1_done=0, done=0, busy=0, frames=0.
- IDLE: start=1 moves to L1 and clears ctr1 and ctr2 to 0. start in any other state is ignored.
- re is combinational: re = (state==L1 || state==L2) && !stall.
- L1 issue: each cycle with re=1 issues row ctr1.
  - If ctr1 < N_IN: ctr1 increments.
  - If ctr1 == N_IN: ctr1 holds and the next state is L1_DRAIN.
  - stall=1: ctr1 and state hold and no row is issued.
- Valid strobes are registered with 1-cycle latency:
  - w1_valid <= re && state==L1; w2_valid <= re && state==L2.
  - w_last <= re && (addr == bias index).
  - Exactly N_IN+1 w1_valid pulses and N_HID+1 w2_valid pulses per frame, in address order, no duplicates; stall gaps are allowed.
- L1_DRAIN (1 cycle): the final w1_valid, w_last and l1_done are high together; next state WAIT_ACT. stall is ignored here.
- WAIT_ACT: re=0. act_ready=1 moves to L2 next cycle; otherwise stay. act_ready already high on entry is accepted on the first WAIT_ACT cycle.
- L2: same issue rule as L1 using ctr2 and bias index N_HID. ctr1 holds N_IN.
- L2_DRAIN (1 cycle): the final w2_valid, w_last and done are high together; frames increments; next state IDLE.
- Unstalled latency from start sampled at cycle 0:
  - L1 issues cycles 1..785; l1_done at cycle 786; WAIT_ACT at 787.
  - With act_ready=1: L2 issues 788..820; done at 821; IDLE at 822.
- abort (any non-IDLE state):
  - Next state IDLE; re=0 in the abort cycle.
  - No l1_done/done pulse; frames is unchanged.
  - A w*_valid for a row issued in the previous cycle still appears.
  - abort has priority over start, stall and act_ready.
- Reset mid-operation: immediate return to reset values; no pulses.
- Address counters never exceed their bias index. No wrap is possible within a frame.

Decomposition:
- Package wb_seq_pkg holds:
  - the state enum (3-bit encoding);
  - default N_IN/N_HID constants;
  - L1_ROWS = N_IN+1 and L2_ROWS = N_HID+1;
  - the bias index localparams.
- One sub-module, wb_addr_cnt: a stall-able up-counter with clear, enable, a terminal-count compare, and a registered valid/last strobe pair. It is instantiated twice (layer 1 and layer 2).
- The FSM, the abort logic and the frame counter stay in the top module.

Test Plan:
- Basic frame, stall=0, act_ready=1: start pulse at cycle 0 -> ctr1 0..784 on cycles 1..785; 785 w1_valid with w_last only on the last; l1_done at 786; ctr2 0..32 on 788..820; done at 821; frames=1; busy low at 822.
- Stall: stall=1 for cycles 10..14 during L1 -> re=0 and ctr1 frozen at 9 for those 5 cycles; w1_valid gaps at 11..15; l1_done delayed to cycle 791; still exactly 785 w1_valid pulses.
- act_ready held low for 20 cycles after l1_done -> re=0 throughout WAIT_ACT; first L2 issue one cycle after act_ready rises; ctr2 starts at 0.
- abort asserted at ctr1=400 -> IDLE next cycle; no l1_done/done; frames unchanged. A following start runs a complete frame from ctr1=0.
- Async reset asserted mid-L2 (ctr2=17) -> all outputs at reset values immediately, frames=0. start ignored during an active frame (pulse at cycle 300) -> exactly one done.
